// File: rtl/aes_input_gather.sv
// Gathers IN_W-wide plaintext/key beats into a 128-bit text block and KEY_W key for the AES core.
// Optional key reuse (blocks carrying text only) is enabled by defining AES_INBUF_KEY_CACHE_EN.
module aes_input_gather #(
  parameter int IN_W  = 32,
  parameter int KEY_W = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [IN_W-1:0]  text_in,
  input  logic [IN_W-1:0]  key_in,
  input  logic             new_key_i,
  output logic [127:0]     text_o,
  output logic [KEY_W-1:0] key_o,
  output logic             ld_o,
  input  logic             done_i,
  output logic             busy_o
);

  localparam int N_T = 128 / IN_W;
  localparam int N_K = KEY_W / IN_W;
  localparam int CW  = $clog2(N_K + 1);

  generate
    if ((IN_W != 32) && (IN_W != 64) && (IN_W != 128)) begin : g_bad_in_w
      $error("aes_input_gather: IN_W must be 32, 64 or 128");
    end
    if (((KEY_W != 128) && (KEY_W != 192) && (KEY_W != 256)) || (KEY_W % IN_W != 0)) begin : g_bad_key_w
      $error("aes_input_gather: KEY_W must be 128/192/256 and a multiple of IN_W");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_LOAD, S_WAIT} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_idx;
  logic             r_key_mode;
  logic             w_key_mode;
  logic             w_new_key;
  logic             w_accept;
  logic             w_last;
  logic [127:0]     r_text;
  logic [KEY_W-1:0] r_key;

`ifdef AES_INBUF_KEY_CACHE_EN
  assign w_new_key = new_key_i;
`else
  logic w_unused_new_key;
  assign w_unused_new_key = new_key_i;
  assign w_new_key        = 1'b1;
`endif

  // Beat 0 index and key mode come straight from the inputs in IDLE; later beats use the latched mode.
  always_comb begin
    w_next     = r_state;
    in_ready_o = 1'b0;
    w_idx      = r_cnt;
    w_key_mode = r_key_mode;
    case (r_state)
      S_IDLE: begin
        in_ready_o = 1'b1;
        w_idx      = '0;
        w_key_mode = w_new_key;
      end
      S_FILL: in_ready_o = 1'b1;
      S_LOAD: w_next = done_i ? S_IDLE : S_WAIT;
      S_WAIT: if (done_i) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (!rst) in_ready_o = 1'b0;
    w_accept = in_valid_i & in_ready_o;
    w_last   = (w_idx == (w_key_mode ? CW'(N_K - 1) : CW'(N_T - 1)));
    if (w_accept) w_next = w_last ? S_LOAD : S_FILL;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_key_mode <= 1'b0;
      r_text     <= '0;
      r_key      <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cnt <= w_last ? '0 : w_idx + CW'(1);
        if (w_idx == '0) r_key_mode <= w_key_mode;
        for (int b = 0; b < N_T; b++)
          if (w_idx == CW'(b)) r_text[b*IN_W +: IN_W] <= text_in;
        if (w_key_mode)
          for (int b = 0; b < N_K; b++)
            if (w_idx == CW'(b)) r_key[b*IN_W +: IN_W] <= key_in;
      end
    end
  end

  assign text_o = r_text;
  assign key_o  = r_key;
  assign ld_o   = (r_state == S_LOAD);
  assign busy_o = (r_state == S_LOAD) || (r_state == S_WAIT);

endmodule

// File: tb/tb_aes_input_gather.sv
// Directed bench for aes_input_gather: three instances (32/128, 64/256, 32/256).
module tb_aes_input_gather;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic         a_valid = 0, a_ready, a_nk = 0, a_ld, a_done = 0, a_busy;
  logic [31:0]  a_text = 0, a_key = 0;
  logic [127:0] a_to, a_ko;

  logic         b_valid = 0, b_ready, b_nk = 0, b_ld, b_done = 0, b_busy;
  logic [63:0]  b_text = 0, b_key = 0;
  logic [127:0] b_to;
  logic [255:0] b_ko;

  logic         c_valid = 0, c_ready, c_nk = 0, c_ld, c_done = 0, c_busy;
  logic [31:0]  c_text = 0, c_key = 0;
  logic [127:0] c_to;
  logic [255:0] c_ko;

  aes_input_gather #(.IN_W(32), .KEY_W(128)) dut_a (
    .clk(clk), .rst(rst), .in_valid_i(a_valid), .in_ready_o(a_ready),
    .text_in(a_text), .key_in(a_key), .new_key_i(a_nk), .text_o(a_to),
    .key_o(a_ko), .ld_o(a_ld), .done_i(a_done), .busy_o(a_busy));

  aes_input_gather #(.IN_W(64), .KEY_W(256)) dut_b (
    .clk(clk), .rst(rst), .in_valid_i(b_valid), .in_ready_o(b_ready),
    .text_in(b_text), .key_in(b_key), .new_key_i(b_nk), .text_o(b_to),
    .key_o(b_ko), .ld_o(b_ld), .done_i(b_done), .busy_o(b_busy));

  aes_input_gather #(.IN_W(32), .KEY_W(256)) dut_c (
    .clk(clk), .rst(rst), .in_valid_i(c_valid), .in_ready_o(c_ready),
    .text_in(c_text), .key_in(c_key), .new_key_i(c_nk), .text_o(c_to),
    .key_o(c_ko), .ld_o(c_ld), .done_i(c_done), .busy_o(c_busy));

  localparam logic [127:0] A_EXP_T = 128'h00000004_00000003_00000002_00000001;
  localparam logic [127:0] A_EXP_K = 128'h000000A3_000000A2_000000A1_000000A0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    checks++; if (a_to !== 128'h0) begin failures++; $display("FAIL rst_text got=%h exp=0", a_to); end
    checks++; if (a_ko !== 128'h0) begin failures++; $display("FAIL rst_key got=%h exp=0", a_ko); end
    checks++; if ({a_ld, a_busy} !== 2'b00) begin failures++; $display("FAIL rst_ld_busy got=%b exp=00", {a_ld, a_busy}); end
    checks++; if ({a_ready, b_ready, c_ready} !== 3'b000) begin failures++; $display("FAIL rst_ready got=%b exp=000", {a_ready, b_ready, c_ready}); end
    rst = 1'b1;
    #1;
    checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL rst_release_ready got=%b exp=1", a_ready); end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 4; i++) begin
      a_valid = 1'b1;
      a_text  = 32'(i + 1);
      a_key   = 32'hA0 + 32'(i);
      checks++; if (a_ld !== 1'b0) begin failures++; $display("FAIL basic_ld_early beat=%0d got=%b exp=0", i, a_ld); end
      tick();
    end
    a_valid = 1'b0;
    checks++; if ({a_ld, a_busy} !== 2'b11) begin failures++; $display("FAIL basic_load got=%b exp=11", {a_ld, a_busy}); end
    checks++; if (a_to !== A_EXP_T) begin failures++; $display("FAIL basic_text got=%h exp=%h", a_to, A_EXP_T); end
    checks++; if (a_ko !== A_EXP_K) begin failures++; $display("FAIL basic_key got=%h exp=%h", a_ko, A_EXP_K); end
    tick();
    checks++; if ({a_ld, a_busy, a_ready} !== 3'b010) begin failures++; $display("FAIL basic_wait got=%b exp=010", {a_ld, a_busy, a_ready}); end
    a_done = 1'b1;
    tick();
    a_done = 1'b0;
    checks++; if ({a_busy, a_ready} !== 2'b01) begin failures++; $display("FAIL basic_idle got=%b exp=01", {a_busy, a_ready}); end
  endtask

  task automatic test_wait_hold();
    int stray;
    for (int i = 0; i < 4; i++) begin
      a_valid = 1'b1;
      a_text  = 32'h10 + 32'(i);
      a_key   = 32'h20 + 32'(i);
      tick();
    end
    tick();
    a_valid = 1'b1;
    a_text  = 32'hDEAD;
    a_key   = 32'hBEEF;
    stray   = 0;
    for (int i = 0; i < 10; i++) begin
      if (a_ready !== 1'b0 || a_busy !== 1'b1) stray++;
      tick();
    end
    checks++; if (stray !== 0) begin failures++; $display("FAIL wait_ready_cycles got=%0d exp=0", stray); end
    checks++; if (a_to[31:0] !== 32'h10) begin failures++; $display("FAIL wait_text_held got=%h exp=00000010", a_to[31:0]); end
    a_done = 1'b1;
    tick();
    a_done = 1'b0;
    checks++; if ({a_busy, a_ready} !== 2'b01) begin failures++; $display("FAIL wait_to_idle got=%b exp=01", {a_busy, a_ready}); end
    checks++; if (a_to[31:0] !== 32'h10) begin failures++; $display("FAIL wait_no_take_on_done got=%h exp=00000010", a_to[31:0]); end
    tick();
    checks++; if (a_to[31:0] !== 32'hDEAD) begin failures++; $display("FAIL wait_take_after got=%h exp=0000dead", a_to[31:0]); end
    checks++; if (a_to[127:96] !== 32'h13) begin failures++; $display("FAIL wait_prior_bits got=%h exp=00000013", a_to[127:96]); end
    for (int i = 1; i < 4; i++) begin
      a_text = 32'h30 + 32'(i);
      tick();
    end
    a_valid = 1'b0;
    checks++; if (a_ld !== 1'b1) begin failures++; $display("FAIL wait_second_ld got=%b exp=1", a_ld); end
    a_done = 1'b1;
    tick();
    a_done = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [127:0] et, ek;
    int pulses;
    for (int i = 0; i < 2; i++) begin
      a_valid = 1'b1;
      a_text  = 32'h40 + 32'(i);
      a_key   = 32'h60 + 32'(i);
      tick();
    end
    a_valid = 1'b0;
    rst = 1'b0;
    tick();
    checks++; if ({a_to, a_ko} !== 256'h0) begin failures++; $display("FAIL mid_rst_data got=%h/%h exp=0", a_to, a_ko); end
    checks++; if ({a_ld, a_busy} !== 2'b00) begin failures++; $display("FAIL mid_rst_ctrl got=%b exp=00", {a_ld, a_busy}); end
    rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (a_ld !== 1'b0) pulses++;
    end
    checks++; if (pulses !== 0) begin failures++; $display("FAIL mid_rst_no_ld got=%0d exp=0", pulses); end
    for (int i = 0; i < 4; i++) begin
      a_valid = 1'b1;
      a_text  = 32'h70 + 32'(i);
      a_key   = 32'h80 + 32'(i);
      et[i*32 +: 32] = a_text;
      ek[i*32 +: 32] = a_key;
      tick();
    end
    a_valid = 1'b0;
    checks++; if (a_ld !== 1'b1) begin failures++; $display("FAIL mid_rst_fresh_ld got=%b exp=1", a_ld); end
    checks++; if ({a_to, a_ko} !== {et, ek}) begin failures++; $display("FAIL mid_rst_fresh_data got=%h/%h exp=%h/%h", a_to, a_ko, et, ek); end
    a_done = 1'b1;
    tick();
    a_done = 1'b0;
  endtask

  task automatic test_gaps();
    int early;
    early = 0;
    for (int i = 0; i < 4; i++) begin
      a_valid = 1'b0;
      a_done  = 1'b1;
      for (int g = 0; g < (i % 3) + 1; g++) begin
        tick();
        if (a_ld !== 1'b0) early++;
      end
      a_done  = 1'b0;
      a_valid = 1'b1;
      a_text  = 32'(i + 1);
      a_key   = 32'hA0 + 32'(i);
      tick();
    end
    a_valid = 1'b0;
    checks++; if (early !== 0) begin failures++; $display("FAIL gaps_ld_early got=%0d exp=0", early); end
    checks++; if (a_ld !== 1'b1) begin failures++; $display("FAIL gaps_ld got=%b exp=1", a_ld); end
    checks++; if ({a_to, a_ko} !== {A_EXP_T, A_EXP_K}) begin failures++; $display("FAIL gaps_data got=%h/%h exp=%h/%h", a_to, a_ko, A_EXP_T, A_EXP_K); end
    a_done = 1'b1;
    tick();
    a_done = 1'b0;
  endtask

  task automatic test_wide();
    logic [255:0] ek;
    for (int i = 0; i < 4; i++) begin
      b_valid = 1'b1;
      b_text  = 64'h1000_0000_0000_0010 + 64'(i);
      b_key   = 64'hC0DE_0000_0000_0000 + 64'(i);
      ek[i*64 +: 64] = b_key;
      checks++; if (b_ld !== 1'b0) begin failures++; $display("FAIL wide_ld_early beat=%0d got=%b exp=0", i, b_ld); end
      tick();
    end
    b_valid = 1'b0;
    checks++; if (b_ld !== 1'b1) begin failures++; $display("FAIL wide_ld got=%b exp=1", b_ld); end
    checks++; if (b_to !== 128'h1000_0000_0000_0011_1000_0000_0000_0010) begin failures++; $display("FAIL wide_text got=%h exp=10000000000000111000000000000010", b_to); end
    checks++; if (b_ko[255:192] !== 64'hC0DE_0000_0000_0003) begin failures++; $display("FAIL wide_key_top got=%h exp=c0de000000000003", b_ko[255:192]); end
    checks++; if (b_ko !== ek) begin failures++; $display("FAIL wide_key got=%h exp=%h", b_ko, ek); end
    b_done = 1'b1;
    tick();
    b_done = 1'b0;
  endtask

  task automatic test_key_cache();
    logic [255:0] e1, e2;
    logic [127:0] et;
    for (int i = 0; i < 8; i++) begin
      c_valid = 1'b1;
      c_nk    = 1'b1;
      c_text  = 32'h1000 + 32'(i);
      c_key   = 32'hC000_0000 + 32'(i);
      e1[i*32 +: 32] = c_key;
      tick();
    end
    c_valid = 1'b0;
    checks++; if (c_ld !== 1'b1) begin failures++; $display("FAIL cache_blk1_ld got=%b exp=1", c_ld); end
    checks++; if (c_ko !== e1) begin failures++; $display("FAIL cache_blk1_key got=%h exp=%h", c_ko, e1); end
    c_done = 1'b1;
    tick();
    c_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      c_valid = 1'b1;
      c_nk    = (i != 0);
      c_text  = 32'h2000 + 32'(i);
      c_key   = 32'hEE00_0000 + 32'(i);
      et[i*32 +: 32] = c_text;
      e2[i*32 +: 32] = c_key;
      tick();
    end
`ifdef AES_INBUF_KEY_CACHE_EN
    c_valid = 1'b0;
    checks++; if (c_ld !== 1'b1) begin failures++; $display("FAIL cache_blk2_ld got=%b exp=1", c_ld); end
    checks++; if (c_ko !== e1) begin failures++; $display("FAIL cache_blk2_key got=%h exp=%h", c_ko, e1); end
`else
    checks++; if (c_ld !== 1'b0) begin failures++; $display("FAIL nocache_blk2_ld_early got=%b exp=0", c_ld); end
    for (int i = 4; i < 8; i++) begin
      c_text = 32'h2000 + 32'(i);
      c_key  = 32'hEE00_0000 + 32'(i);
      e2[i*32 +: 32] = c_key;
      tick();
    end
    c_valid = 1'b0;
    checks++; if (c_ld !== 1'b1) begin failures++; $display("FAIL nocache_blk2_ld got=%b exp=1", c_ld); end
    checks++; if (c_ko !== e2) begin failures++; $display("FAIL nocache_blk2_key got=%h exp=%h", c_ko, e2); end
`endif
    checks++; if (c_to !== et) begin failures++; $display("FAIL cache_blk2_text got=%h exp=%h", c_to, et); end
    c_nk   = 1'b0;
    c_done = 1'b1;
    tick();
    c_done = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait_hold();
    test_reset_mid();
    test_gaps();
    test_wide();
    test_key_cache();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_input_gather.md
AES_INPUT_GATHER -- requirements
Module: aes_input_gather

Interface
REQ-001 SHALL have parameter IN_W, default 32, input beat width; legal values 32, 64, 128.
REQ-002 SHALL have parameter KEY_W, default 128, key width; legal values 128, 192, 256; KEY_W SHALL be a multiple of IN_W (e.g. IN_W=128 with KEY_W=192 is illegal).
REQ-003 SHALL use reset rst, synchronous, active-low, and clock clk.
REQ-004 SHALL have ports:
  clk  in  1  clock, rising edge
  rst  in  1  synchronous active-low reset
  in_valid_i  in  1  beat valid
  in_ready_o  out  1  beat accept
  text_in  in  IN_W  plaintext beat
  key_in  in  IN_W  key beat
  new_key_i  in  1  block carries new key, sampled with beat 0
  text_o  out  128  assembled text block
  key_o  out  KEY_W  assembled key
  ld_o  out  1  block-ready pulse to core
  done_i  in  1  core finished current block
  busy_o  out  1  block held for core

Function
REQ-005 SHALL define N_T = 128/IN_W text beats, N_K = KEY_W/IN_W key beats, and N = N_K beats per block when a key is loaded.
REQ-006 SHALL accept a beat only in a cycle where in_valid_i=1 and in_ready_o=1.
REQ-007 SHALL write accepted beat i to text_o[i*IN_W +: IN_W] if i<N_T, and to key_o[i*IN_W +: IN_W] if key loading is active and i<N_K; beat 0 SHALL fill the LSBs.
REQ-008 SHALL implement states IDLE, FILL, LOAD, WAIT, all registered.
REQ-009 IDLE: in_ready_o=1; accepting beat 0 SHALL go to FILL, or to LOAD if the block is one beat long.
REQ-010 FILL: in_ready_o=1; each accepted beat SHALL increment the beat counter; accepting the last beat SHALL go to LOAD; in_valid_i=0 SHALL hold state and counter with no timeout.
REQ-011 LOAD: ld_o=1 for exactly one cycle and in_ready_o=0; next state SHALL be WAIT, or IDLE if done_i=1 in that cycle.
REQ-012 WAIT: in_ready_o=0; done_i=1 SHALL go to IDLE; otherwise hold.
REQ-013 done_i SHALL be ignored in IDLE and FILL.
REQ-014 ld_o SHALL assert in the cycle after the last beat is accepted (latency 1).
REQ-015 busy_o SHALL be 1 in LOAD and WAIT, and 0 otherwise.
REQ-016 text_o and key_o SHALL hold stable from LOAD until the next beat-0 acceptance; bits not written by the current block SHALL keep their prior values.
REQ-017 A new beat SHALL NOT be accepted in the same cycle done_i returns the block to IDLE; acceptance resumes the following cycle.

Reset
REQ-018 With rst=0 at a clock edge, the block SHALL go to IDLE with beat counter 0, text_o=0, key_o=0, ld_o=0, busy_o=0; in_ready_o SHALL be 0 while rst=0.
REQ-019 Reset mid-FILL or mid-WAIT SHALL discard the partial block; no ld_o pulse SHALL follow.

Configuration
REQ-020 Macro AES_INBUF_KEY_CACHE_EN SHALL control key reuse.
REQ-021 With AES_INBUF_KEY_CACHE_EN defined: new_key_i SHALL be sampled on beat-0 acceptance. If 1, the block is N_K beats with key loading. If 0, the block is N_T beats, key_in is ignored, and key_o is unchanged.
REQ-022 With AES_INBUF_KEY_CACHE_EN undefined: new_key_i SHALL be ignored, and every block SHALL be N_K beats with key loading.

Verification
REQ-023 IN_W=32, KEY_W=128; beats text 0x00000001..0x00000004, key 0xA0..0xA3 on consecutive cycles -> ld_o pulses the cycle after beat 3; text_o=0x00000004_00000003_00000002_00000001; key_o=0x000000A3_000000A2_000000A1_000000A0.
REQ-024 IN_W=64, KEY_W=256; 4 beats, text only on beats 0-1 -> ld_o after beat 3; text_o upper half = beat 1 text; key_o[255:192] = beat 3 key.
REQ-025 In WAIT, assert in_valid_i for 10 cycles with done_i=0 -> in_ready_o=0 and no beat taken; done_i=1 -> IDLE next cycle, beat accepted the cycle after.
REQ-026 Drop rst after beat 2 of 4 -> all outputs 0 next cycle, no ld_o; a fresh 4-beat block then completes normally.
REQ-027 With AES_INBUF_KEY_CACHE_EN defined, IN_W=32, KEY_W=256: block 1 has new_key_i=1 (8 beats); block 2 has new_key_i=0 -> ld_o after 4 beats and key_o equals block 1's key.
REQ-028 Insert in_valid_i=0 gaps of 1-3 cycles between beats -> same text_o/key_o as the gap-free run; ld_o latency is 1 after the last beat.
